// File: rtl/fsqrt_arbiter.sv
// Round-robin front end for a shared, unstallable fixed-latency fsqrt pipe.
// Tracks slot ownership alongside the pipe and steers each result into its requester's response register.
module fsqrt_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_y,
  output logic [31:0]          sq_x,
  input  logic [31:0]          sq_y,
  output logic                 idle
);

  logic [NREQ-1:0] w_busy;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic [IDW-1:0]  w_idx;
  logic            w_gnt_any;
  logic [31:0]     w_req_x [NREQ];

  logic [IDW-1:0]  r_rr_ptr;
  logic [LAT-1:0]  r_trk_vld;
  logic [IDW-1:0]  r_trk_id [LAT];

  logic            w_wb_vld;
  logic [IDW-1:0]  w_wb_id;

  assign w_elig = req_valid & ~w_busy;

  // Rotating priority: the requester just after the last winner is searched first.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gid     = '0;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_any && w_elig[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gid     = w_idx;
      end
    end
    if (rst) begin
      w_gnt_any = 1'b0;
    end
  end

  assign w_grant   = w_gnt_any ? (NREQ'(1) << w_gid) : '0;
  assign req_ready = w_grant;
  assign sq_x      = w_gnt_any ? w_req_x[w_gid] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= IDW'(NREQ - 1);
      r_trk_vld <= '0;
    end else begin
      r_trk_vld[0] <= w_gnt_any;
      for (int k = 1; k < LAT; k++) begin
        r_trk_vld[k] <= r_trk_vld[k-1];
      end
      if (w_gnt_any) begin
        r_rr_ptr <= w_gid;
      end
    end
  end

  // Owner ids only matter when the matching valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    r_trk_id[0] <= w_gid;
    for (int k = 1; k < LAT; k++) begin
      r_trk_id[k] <= r_trk_id[k-1];
    end
  end

  assign w_wb_vld = r_trk_vld[LAT-1];
  assign w_wb_id  = r_trk_id[LAT-1];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_y;
    logic        w_rsp_hs;
    logic        w_wb_hit;

    assign w_req_x[gi] = req_x[32*gi +: 32];
    assign w_rsp_hs    = r_valid & rsp_ready[gi];
    assign w_wb_hit    = w_wb_vld && (w_wb_id == IDW'(gi));

    // busy spans issue through consumption, so a writeback never finds r_valid set.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_y     <= '0;
      end else begin
        if (w_wb_hit) begin
          r_valid <= 1'b1;
          r_y     <= sq_y;
        end else if (w_rsp_hs) begin
          r_valid <= 1'b0;
        end
        if (w_grant[gi]) begin
          r_busy <= 1'b1;
        end else if (w_rsp_hs) begin
          r_busy <= 1'b0;
        end
      end
    end

    assign w_busy[gi]        = r_busy;
    assign rsp_valid[gi]     = r_valid;
    assign rsp_y[32*gi +: 32] = r_y;
  end

  assign idle = ~|w_busy;

endmodule
